// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
// State encoding for the serial_add_ctrl FSM and the default operand width.
// No timing or flow control lives here.
package serial_add_pkg;

   localparam int SA_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sa_state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// 1-bit full adder built from two half adders plus an OR for the carry.
// Purely combinational, zero latency.
// No flow control.
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b;
   assign carry = a & b;
endmodule

module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);
   logic s1;
   logic c1;
   logic c2;

   half_adder u_ha0 (.a(a),  .b(b),   .sum(s1),  .carry(c1));
   half_adder u_ha1 (.a(s1), .b(cin), .sum(sum), .carry(c2));

   assign carry = c1 | c2;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder {carry,sum} = a + b + cin, LSB first, one bit per cycle; SERIAL_ADD_OVF_EN adds ovf.
// Latency: out_valid rises WIDTH cycles after the accept edge; at most one operation per WIDTH+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             busy
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int            IW   = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   sa_state_t        state_q;
   sa_state_t        state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             cin_q;
   logic [IW-1:0]    idx_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             c_run;
   logic             fa_s;
   logic             fa_c;

   // The first bit takes the latched carry-in so carry only moves during SHIFT.
   assign c_run = (idx_q == '0) ? cin_q : carry_q;

   fa_cell u_fa (
      .a    (a_q[idx_q]),
      .b    (b_q[idx_q]),
      .cin  (c_run),
      .sum  (fa_s),
      .carry(fa_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)       state_d = SHIFT;
         SHIFT:   if (idx_q == LAST)  state_d = DONE;
         DONE:    if (out_ready)      state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               a_q   <= a;
               b_q   <= b;
               cin_q <= cin;
               idx_q <= '0;
            end
            SHIFT: begin
               sum_q[idx_q] <= fa_s;
               carry_q      <= fa_c;
               if (idx_q != LAST) idx_q <= idx_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   logic ovf_q;

   // Overflow is the carry into the MSB xor the carry out of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   ovf_q <= 1'b0;
      else if (state_q == SHIFT && idx_q == LAST)   ovf_q <= c_run ^ fa_c;
   end

   assign ovf = ovf_q;
`endif

   assign sum   = sum_q;
   assign carry = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed plus random checks of serial_add_ctrl (WIDTH=8) against an arithmetic reference.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       carry;
   logic       busy;
`ifdef SERIAL_ADD_OVF_EN
   logic       ovf;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .carry    (carry),
      .busy     (busy)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf      (ovf)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One operation: drive, measure latency, hold in DONE, spam in_valid if asked, handshake.
   task automatic do_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                        input int hold, input bit spam);
      logic [8:0] ref_full;
      logic       ref_ovf;
      int         k;
      int         w;
      ref_full = {1'b0, xa} + {1'b0, xb} + {8'd0, xc};
      ref_ovf  = (xa[7] == xb[7]) && (ref_full[7] != xa[7]);
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      check("in_ready_before_op", {31'd0, in_ready}, 32'd1);
      a = xa; b = xb; cin = xc; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      if (spam) begin
         a = ~xa; b = ~xb; cin = ~xc; in_valid = 1'b1;
      end else begin
         in_valid = 1'b0;
      end
      check("busy_in_shift", {30'd0, busy, in_ready}, 32'd2);
      k = 0;
      while (!out_valid && k < 40) begin
         k++;
         @(negedge clk);
      end
      check("latency", k, 32'd8);
      for (int i = 0; i < hold; i++) begin
         check("hold_sum",   {24'd0, sum}, {24'd0, ref_full[7:0]});
         check("hold_ready", {30'd0, in_ready, out_valid}, 32'd1);
         @(negedge clk);
      end
      check("sum",   {24'd0, sum},   {24'd0, ref_full[7:0]});
      check("carry", {31'd0, carry}, {31'd0, ref_full[8]});
`ifdef SERIAL_ADD_OVF_EN
      check("ovf",   {31'd0, ovf},   {31'd0, ref_ovf});
`else
      if (ref_ovf) ref_ovf = 1'b0;
`endif
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_handshake", {29'd0, in_ready, out_valid, busy}, 32'd4);
      check("post_sum", {23'd0, carry, sum}, {23'd0, ref_full});
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      #12;
      check("rst_flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
      check("rst_data",  {23'd0, carry, sum}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(8'h0F, 8'h01, 1'b0, 0, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
      do_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
      do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
      do_op(8'h80, 8'h7F, 1'b0, 0, 1'b0);
      do_op(8'hA5, 8'h3C, 1'b1, 5, 1'b1);

      // Reset in the middle of SHIFT, with bit index at 3.
      a = 8'h55; b = 8'h33; cin = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
      check("midrst_data",  {23'd0, carry, sum}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("no_result_after_rst", {30'd0, out_valid, busy}, 32'd0);
      end
      do_op(8'h55, 8'h33, 1'b1, 0, 1'b0);

      for (int t = 0; t < 16; t++) begin
         do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
               1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand set on a, b and cin is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: the addends.
REQ-007 The block SHALL have port cin, input, 1 bit: the carry-in.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port sum, output, WIDTH bits: the result sum.
REQ-011 The block SHALL have port carry, output, 1 bit: the carry-out of the MSB.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 The block SHALL compute {carry,sum} = a + b + cin bit-serially, one bit per cycle, LSB first, using a single 1-bit adder cell.
REQ-014 The state machine SHALL have three states:
- IDLE: in_ready=1.
- SHIFT: computes one bit per cycle.
- DONE: out_valid=1.
REQ-015 Operand acceptance: on an edge with IDLE and in_valid=1, the block SHALL latch a, b and cin, clear the bit index and enter SHIFT.
REQ-016 In SHIFT, each edge SHALL:
- compute bit i from a[i], b[i] and the carry register;
- store the result into sum[i] and update the carry register;
- increment i.
REQ-017 After the edge computing bit WIDTH-1, the block SHALL enter DONE, so out_valid rises exactly WIDTH cycles after the acceptance edge.
REQ-018 In DONE, the block SHALL hold sum and carry stable while out_ready=0, and SHALL return to IDLE on the edge where out_ready=1.
REQ-019 in_ready SHALL be 0 in SHIFT and DONE; in_valid asserted there SHALL be ignored without side effects.
REQ-020 The block SHALL not accept new operands in the same cycle as a result handshake, giving one operation per WIDTH+2 cycles minimum.
REQ-021 sum and carry SHALL be undefined-free in every state and SHALL change only in SHIFT.
REQ-022 The bit index SHALL be $clog2(WIDTH) bits wide and SHALL never wrap past WIDTH-1.

Reset
REQ-023 Asserting rst_n=0 at any time, including mid-SHIFT or in DONE, SHALL immediately force the following:
- state=IDLE;
- in_ready=1, out_valid=0, busy=0;
- sum=0, carry=0;
- index=0, operand registers=0.
REQ-024 An operation interrupted by reset SHALL be discarded and SHALL produce no result.

Configuration
REQ-025 Macro SERIAL_ADD_OVF_EN, when defined, SHALL add the following:
- output ovf, 1 bit, reset 0;
- ovf is valid with out_valid and equals the carry into the MSB XOR carry-out (two's-complement overflow).
REQ-026 When SERIAL_ADD_OVF_EN is undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package serial_add_pkg SHALL hold the state enum type (IDLE, SHIFT, DONE) and constant SA_DEFAULT_WIDTH=8.
REQ-028 The 1-bit adder cell SHALL be a sub-module fa_cell (ports a, b, cin, sum, carry), built from two half_adder instances plus an OR.

Verification (WIDTH=8)
REQ-029 a=0x0F, b=0x01, cin=0 SHALL yield sum=0x10 and carry=0, with out_valid exactly 8 cycles after acceptance.
REQ-030 a=0xFF, b=0x01, cin=0 SHALL yield sum=0x00 and carry=1; a=0xFF, b=0xFF, cin=1 SHALL yield sum=0xFF and carry=1.
REQ-031 a=0x7F, b=0x01 with SERIAL_ADD_OVF_EN defined SHALL yield ovf=1 and sum=0x80; a=0x80, b=0x7F SHALL yield ovf=0.
REQ-032 With out_ready held at 0 for 5 cycles in DONE, sum and carry SHALL stay stable and in_ready SHALL stay 0; new in_valid pulses during SHIFT and DONE SHALL be ignored.
REQ-033 rst_n pulsed low at SHIFT bit 3 SHALL give out_valid=0, sum=0 and in_ready=1 immediately, and the next operation afterwards SHALL produce the correct result.
